// File: rtl/demux1x5_buffered.sv
// Buffered 1-to-5 router: one source beat is steered by a 3-bit select into one of
// five one-entry holding registers, each with its own valid/ready handshake.
// Beats whose select decodes to no destination are consumed, flagged for one cycle
// and counted in a saturating counter.
module demux1x5_buffered #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic             sel_err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned NUM_DEST = 5;

  // Holding registers, one per destination
  logic [WIDTH-1:0]    data_q [NUM_DEST];
  logic [WIDTH-1:0]    data_d [NUM_DEST];
  logic [NUM_DEST-1:0] valid_q;
  logic [NUM_DEST-1:0] valid_d;

  // Drop reporting
  logic                sel_err_q;
  logic                sel_err_d;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_d;

  // Per-cycle decode
  logic [NUM_DEST-1:0] sel_onehot;
  logic [NUM_DEST-1:0] load;
  logic [NUM_DEST-1:0] drain;
  logic                accept;
  logic                drop;

  // Select decode; an out-of-range select yields an all-zero one-hot vector.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < NUM_DEST; k++) begin
      sel_onehot[k] = (in_select == 3'(k));
    end
  end

  // Ready depends only on the addressed slot, never on in_valid. With no valid
  // destination the mask is empty, so invalid beats are always accepted. During
  // reset valid_q is zero, which keeps in_ready high.
  always_comb begin
    in_ready = ~|(sel_onehot & valid_q & ~out_ready);
    accept   = in_valid & in_ready;
    load     = {NUM_DEST{accept}} & sel_onehot;
    drain    = valid_q & out_ready;
    drop     = accept & ~|sel_onehot;
  end

  // Next state of each slot: load wins over drain so a full slot can be refilled
  // in the same cycle it empties; a plain drain keeps the last data.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned k = 0; k < NUM_DEST; k++) begin
      data_d[k] = data_q[k];
      if (load[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Next state of the drop flag and saturating drop counter
  always_comb begin
    sel_err_d  = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Slot registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NUM_DEST; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < NUM_DEST; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Drop flag and counter registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out1      = data_q[0];
  assign out2      = data_q[1];
  assign out3      = data_q[2];
  assign out4      = data_q[3];
  assign out5      = data_q[4];
  assign out_valid = valid_q;
  assign sel_err   = sel_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux1x5_buffered.sv
// Directed bench for demux1x5_buffered: hand-computed expectations checked with
// immediate assertions. Inputs change 1 time unit after the rising edge and
// outputs are sampled there too, away from the active edge.
module tb_demux1x5_buffered;

  logic        CLK;
  logic        RESET;
  logic [31:0] in_data;
  logic [2:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] out3;
  logic [31:0] out4;
  logic [31:0] out5;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic        sel_err;
  logic [7:0]  drop_cnt;

  int unsigned n_checks;
  int unsigned n_fails;

  demux1x5_buffered #(.WIDTH(32), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    RESET     = 1'b1;
    in_data   = '0;
    in_select = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    // 1. Reset state
    #2;
    check("rst_out_valid", {27'd0, out_valid}, 32'h0);
    check("rst_out1", out1, 32'h0);
    check("rst_out3", out3, 32'h0);
    check("rst_out5", out5, 32'h0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'h0);
    check("rst_sel_err", {31'd0, sel_err}, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'h1);
    #10;
    RESET = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'h1);
    check("post_rst_out_valid", {27'd0, out_valid}, 32'h0);

    // 2. Load slot 2, stall a second beat to it, route that beat to slot 0
    in_data = 32'hDEADBEEF; in_select = 3'd2; in_valid = 1'b1;
    #1;
    check("s2_first_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("s2_out_valid", {27'd0, out_valid}, 32'h4);
    check("s2_out3", out3, 32'hDEADBEEF);
    in_data = 32'hCAFEF00D;
    #1;
    check("s2_stall_ready", {31'd0, in_ready}, 32'h0);
    tick();
    check("s2_stall_out3", out3, 32'hDEADBEEF);
    check("s2_stall_out_valid", {27'd0, out_valid}, 32'h4);
    in_select = 3'd0;
    #1;
    check("s2_other_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("s2_out1", out1, 32'hCAFEF00D);
    check("s2_both_valid", {27'd0, out_valid}, 32'h5);

    // 3. Refill a full slot in the same cycle it drains
    out_ready = 5'b00100; in_data = 32'h12345678; in_select = 3'd2;
    #1;
    check("s3_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("s3_out3", out3, 32'h12345678);
    check("s3_out_valid", {27'd0, out_valid}, 32'h5);
    in_valid = 1'b0; out_ready = 5'b00101;
    tick();
    check("s3_drained_valid", {27'd0, out_valid}, 32'h0);
    check("s3_held_out3", out3, 32'h12345678);
    check("s3_held_out1", out1, 32'hCAFEF00D);

    // 4. Invalid selects: flag, count, saturate
    out_ready = '0; in_valid = 1'b1; in_select = 3'd1; in_data = 32'h11111111;
    tick();
    check("s4_slot1_valid", {27'd0, out_valid}, 32'h2);
    in_select = 3'd6; in_data = 32'h00000BAD;
    #1;
    check("s4_inv_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("s4_sel_err", {31'd0, sel_err}, 32'h1);
    check("s4_drop_cnt", {24'd0, drop_cnt}, 32'h1);
    check("s4_out_valid", {27'd0, out_valid}, 32'h2);
    check("s4_out2", out2, 32'h11111111);
    in_valid = 1'b0;
    tick();
    check("s4_sel_err_clear", {31'd0, sel_err}, 32'h0);
    check("s4_drop_cnt_hold", {24'd0, drop_cnt}, 32'h1);
    in_valid = 1'b1; in_select = 3'd7;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) check("s4_drop_cnt_101", {24'd0, drop_cnt}, 32'd101);
      if (i == 253) check("s4_drop_cnt_reach", {24'd0, drop_cnt}, 32'd255);
    end
    check("s4_drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
    check("s4_sel_err_burst", {31'd0, sel_err}, 32'h1);
    check("s4_burst_out_valid", {27'd0, out_valid}, 32'h2);
    in_valid = 1'b0;
    tick();
    check("s4_sel_err_end", {31'd0, sel_err}, 32'h0);
    check("s4_drop_cnt_end", {24'd0, drop_cnt}, 32'd255);

    // 5. Full-throughput stream into slot 4
    out_ready = 5'b10000; in_select = 3'd4; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'(i);
      #1;
      check("s5_ready", {31'd0, in_ready}, 32'h1);
      tick();
      check("s5_out5", out5, 32'(i));
      check("s5_valid4", {31'd0, out_valid[4]}, 32'h1);
    end

    // 6. Asynchronous reset mid-stream, then resume
    in_data = 32'd200;
    #2;
    RESET = 1'b1;
    #1;
    check("s6_rst_out_valid", {27'd0, out_valid}, 32'h0);
    check("s6_rst_out5", out5, 32'h0);
    check("s6_rst_out2", out2, 32'h0);
    check("s6_rst_drop_cnt", {24'd0, drop_cnt}, 32'h0);
    check("s6_rst_sel_err", {31'd0, sel_err}, 32'h0);
    check("s6_rst_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("s6_rst_held_valid", {27'd0, out_valid}, 32'h0);
    #2;
    RESET = 1'b0;
    out_ready = '0; in_select = 3'd3; in_data = 32'h00000055;
    tick();
    check("s6_resume_out4", out4, 32'h00000055);
    check("s6_resume_valid", {27'd0, out_valid}, 32'h8);
    in_valid = 1'b0;
    tick();
    check("s6_resume_hold", {27'd0, out_valid}, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
